// File: rtl/fifo_new_single_clk.sv
// Single-clock byte FIFO with occupancy count, status flags and overflow/underflow reporting.
// Define STICKY_FLAGS_EN to make fifo_overflow/fifo_underflow latch until rst instead of pulsing.
module fifo_new_single_clk #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 8,
    parameter int THRESHOLD  = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic [CNT_WIDTH-1:0]  fifo_counter,
    output logic                  fifo_threshold,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic [DATA_WIDTH-1:0] buf_out_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  wr_accept_s;
    logic                  rd_accept_s;

    assign fifo_counter   = count_r;
    assign buf_out        = buf_out_r;
    assign fifo_overflow  = overflow_r;
    assign fifo_underflow = underflow_r;

    // Status decodes and accept qualification; full/empty gate the requests.
    always_comb begin
        buf_empty      = (count_r == {CNT_WIDTH{1'b0}});
        buf_full       = (count_r == CNT_WIDTH'(DEPTH));
        fifo_threshold = (count_r >= CNT_WIDTH'(THRESHOLD));
        wr_accept_s    = wr_en & ~buf_full;
        rd_accept_s    = rd_en & ~buf_empty;
    end

    // Storage array: not reset, so stale contents survive rst but are unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept_s) begin
            mem_r[wr_ptr_r] <= buf_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and read data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r  <= {ADDR_WIDTH{1'b0}};
            count_r   <= {CNT_WIDTH{1'b0}};
            buf_out_r <= {DATA_WIDTH{1'b0}};
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_accept_s) begin
                rd_ptr_r  <= rd_ptr_r + ADDR_WIDTH'(1);
                buf_out_r <= mem_r[rd_ptr_r];
            end else begin
                rd_ptr_r  <= rd_ptr_r;
                buf_out_r <= buf_out_r;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   count_r <= count_r + CNT_WIDTH'(1);
                2'b01:   count_r <= count_r - CNT_WIDTH'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Error indications, either per-cycle pulses or latched until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
`ifdef STICKY_FLAGS_EN
            overflow_r  <= overflow_r  | (wr_en & buf_full);
            underflow_r <= underflow_r | (rd_en & buf_empty);
`else
            overflow_r  <= wr_en & buf_full;
            underflow_r <= rd_en & buf_empty;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_new_single_clk.sv
// Self-checking bench for fifo_new_single_clk: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fifo_new_single_clk;

    localparam int DEPTH = 64;
`ifdef STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] buf_in, buf_out, fifo_counter;
    logic       buf_empty, buf_full, fifo_threshold, fifo_overflow, fifo_underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] m_out;
    logic       m_ovf, m_udf;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] exp_out;
        int         exp_cnt;
        logic       exp_empty;
    } vec_t;
    vec_t vecs[15];

    fifo_new_single_clk dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .buf_in(buf_in),
        .buf_out(buf_out), .buf_empty(buf_empty), .buf_full(buf_full),
        .fifo_counter(fifo_counter), .fifo_threshold(fifo_threshold),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, advance the reference model, then compare every output with it.
    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        bit full, empty;
        rst = r; wr_en = w; rd_en = rd; buf_in = d;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_out = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            m_ovf = (STICKY ? m_ovf : 1'b0) | (w & full);
            m_udf = (STICKY ? m_udf : 1'b0) | (rd & empty);
            if (rd && !empty) m_out = mq.pop_front();
            if (w && !full) mq.push_back(d);
        end
        #1;
        chk("model_out",   buf_out,        m_out);
        chk("model_count", fifo_counter,   mq.size());
        chk("model_empty", buf_empty,      mq.size() == 0);
        chk("model_full",  buf_full,       mq.size() == DEPTH);
        chk("model_thr",   fifo_threshold, mq.size() >= 48);
        chk("model_ovf",   fifo_overflow,  m_ovf);
        chk("model_udf",   fifo_underflow, m_udf);
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = 8'h00;
        m_out = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;

        for (int i = 0; i < 10; i++)
            vecs[i] = '{wr: 1'b1, rd: 1'b0, din: 8'(i + 1), exp_out: 8'h00,
                        exp_cnt: i + 1, exp_empty: 1'b0};
        for (int i = 0; i < 5; i++)
            vecs[10 + i] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, exp_out: 8'(i + 1),
                             exp_cnt: 9 - i, exp_empty: 1'b0};

        // Reset state
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_empty", buf_empty, 1'b1);
        chk("rst_full", buf_full, 1'b0);
        chk("rst_count", fifo_counter, 8'd0);
        chk("rst_out", buf_out, 8'h00);
        chk("rst_ovf", fifo_overflow, 1'b0);
        chk("rst_udf", fifo_underflow, 1'b0);

        // Write 0x01..0x0A then five reads
        foreach (vecs[i]) begin
            step(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk("vec_out", buf_out, vecs[i].exp_out);
            chk("vec_count", fifo_counter, vecs[i].exp_cnt);
            chk("vec_empty", buf_empty, vecs[i].exp_empty);
        end

        // Fill to 64; threshold first asserts at 48
        for (int i = 0; i < 59; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(8'h0B + i));
            if (i == 41) chk("thr_at47", fifo_threshold, 1'b0);
            if (i == 42) chk("thr_at48", fifo_threshold, 1'b1);
        end
        chk("fill_count", fifo_counter, 8'd64);
        chk("fill_full", buf_full, 1'b1);

        // Write while full
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        chk("ovf_flag", fifo_overflow, 1'b1);
        chk("ovf_count", fifo_counter, 8'd64);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_after", fifo_overflow, STICKY);

        // Drain 64 with wrap, data 0x06..0x45
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_data", buf_out, 8'(8'h06 + i));
        end
        chk("drain_empty", buf_empty, 1'b1);

        // Read while empty
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_flag", fifo_underflow, 1'b1);
        chk("udf_hold", buf_out, 8'h45);

        // Simultaneous read/write at count 10
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'h90 + i));
            chk("both_count", fifo_counter, 8'd10);
            chk("both_data", buf_out, 8'(8'h80 + i));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("both_order", buf_out, (i < 7) ? 8'(8'h83 + i) : 8'(8'h90 + i - 7));
        end

        // Simultaneous on empty and on full
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        chk("empty_both_cnt", fifo_counter, 8'd1);
        chk("empty_both_udf", fifo_underflow, 1'b1);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("full_both_cnt", fifo_counter, 8'd63);
        chk("full_both_out", buf_out, 8'h5A);
        chk("full_both_ovf", fifo_overflow, 1'b1);

        // Reset mid-operation discards contents
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("midrst_count", fifo_counter, 8'd0);
        chk("midrst_ovf", fifo_overflow, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("midrst_out", buf_out, 8'h00);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 4000; i++) begin
            int bias;
            bias = (i / 500) % 3;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)),
                 $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
